// File: rtl/apb_master_ip.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_ip
//  Description : APB requester. Turns a valid/ready command into one APB
//                SETUP + ACCESS transfer and returns read data, or a timeout
//                flag, on a single-cycle response strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_ip #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PWRITE,
    output logic                  PSEL,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    // A timeout of 0 disables aborting; the counter then still needs 1 bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] c_timeout_lim = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam bit               c_timeout_en  = (TIMEOUT_CYCLES != 0);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_timeout_hit;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_timeout;

    assign w_accept      = (r_state == c_st_idle) && cmd_valid;
    assign w_cnt_inc     = r_wait_cnt + c_cnt_one;
    // Abort on the edge where this wait cycle would bring the count to the limit.
    assign w_timeout_hit = c_timeout_en && !PREADY && (w_cnt_inc == c_timeout_lim);

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SETUP -> ACCESS -> IDLE on ready or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:   if (cmd_valid) w_state_nxt = c_st_setup;
            c_st_setup:  w_state_nxt = c_st_access;
            c_st_access: if (PREADY || w_timeout_hit) w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    // Command capture, wait counting and response generation.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_wait_cnt    <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_paddr    <= cmd_addr;
                r_pwdata   <= cmd_wdata;
                r_pwrite   <= cmd_write;
                r_wait_cnt <= '0;
            end
            if (r_state == c_st_access) begin
                if (PREADY) begin
                    r_rsp_valid   <= 1'b1;
                    r_rsp_timeout <= 1'b0;
                    r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                end else begin
                    r_wait_cnt <= w_cnt_inc;
                    if (w_timeout_hit) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                    end
                end
            end
        end
    end

    // Bus strobes decode directly from the state register so PENABLE can
    // never lead PSEL and both drop together on the same edge.
    assign PSEL        = (r_state != c_st_idle);
    assign PENABLE     = (r_state == c_st_access);
    assign cmd_ready   = (r_state == c_st_idle) && !PRESET;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign PWRITE      = r_pwrite;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: doc/apb_master_ip.md
Name: apb_master_ip

Overview:
APB requester (master) that drives the same PCLK-domain APB bus our apb_slave_ip responds on. It converts a simple valid/ready command port into APB SETUP/ACCESS transfers and returns read data or a timeout flag on a one-cycle response strobe. It becomes the stimulus-side DUT in the APB top and can replace the program-block driver for directed and system-level checks.

Parameters:
ADDR_WIDTH, 32, width of PADDR and cmd_addr
DATA_WIDTH, 32, width of PWDATA/PRDATA, cmd_wdata, rsp_rdata
TIMEOUT_CYCLES, 16, maximum ACCESS cycles allowed with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  input  1  bus clock; all logic on rising edge
PRESET  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  master can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle pulse: transfer finished
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_timeout  output  1  qualifies rsp_valid: transfer aborted by timeout
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PWRITE  output  1  APB direction
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PRDATA  input  DATA_WIDTH  APB read data from slave
PREADY  input  1  APB ready from slave

Behaviour:
- One clock (PCLK); reset is synchronous and active-high (PRESET). While PRESET is high at an edge: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, wait counter=0. cmd_ready=0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1. On an edge with cmd_valid&&cmd_ready, capture cmd_addr/cmd_wdata/cmd_write into PADDR/PWDATA/PWRITE and go to SETUP. cmd_* are ignored when cmd_ready=0.
- SETUP: PSEL=1, PENABLE=0. Lasts exactly one cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - On an edge with PREADY=1: transfer completes. Next cycle rsp_valid=1 and rsp_timeout=0. For reads, rsp_rdata = PRDATA sampled at that edge; for writes, rsp_rdata=0. PSEL and PENABLE return to 0 and state=IDLE.
  - On an edge with PREADY=0: increment the wait counter. If TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES: abort. Next cycle rsp_valid=1, rsp_timeout=1, rsp_rdata=0, PSEL=PENABLE=0, state=IDLE.
- Wait counter clears on entry to SETUP. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
- PADDR, PWDATA and PWRITE are stable from SETUP through the end of ACCESS. After completion they keep their last values (not cleared).
- PREADY and PRDATA are ignored outside ACCESS.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata and rsp_timeout hold their value until the next response.
- Latency: accept edge → SETUP (cycle 1) → ACCESS (cycle 2) → rsp_valid in cycle 2+N+1, where N = wait cycles. With zero waits, rsp_valid comes 3 cycles after accept, and cmd_ready is high in the same cycle as rsp_valid. Peak throughput is one transfer per 3 cycles.
- PSEL never goes high outside SETUP/ACCESS. PENABLE is never high without PSEL. PENABLE never rises on the first PSEL cycle.
- Reset mid-transfer (SETUP or ACCESS): all outputs take reset values on that edge, no rsp_valid is generated, and the pending command is discarded.
- Simultaneous PRESET and cmd_valid: reset wins and the command is not accepted.

Test Plan:
- Reset: hold PRESET=1 for 3 cycles with cmd_valid=1 → PSEL=PENABLE=0, cmd_ready=0, rsp_valid=0. After release, cmd_ready=1 on the next cycle.
- Zero-wait write then read: slave WAIT_CYCLES_COUNT=0; write addr 0x04 data 0xDEADBEEF, then read 0x04 → each transfer gives one SETUP cycle and one ACCESS cycle, and rsp_valid 3 cycles after accept. Read returns rsp_rdata=0xDEADBEEF, rsp_timeout=0.
- Wait states: slave WAIT_CYCLES_COUNT=3; read addr 0x08 → PENABLE high for 4 cycles, PADDR stable at 0x08 throughout, rsp_valid 6 cycles after accept.
- Timeout: TIMEOUT_CYCLES=4 with PREADY tied 0 → PENABLE high for exactly 4 cycles, then rsp_valid=1, rsp_timeout=1, rsp_rdata=0, PSEL=0, cmd_ready=1.
- Back-to-back: cmd_valid held high for 4 writes to 0x00/0x04/0x08/0x0C → one transfer every 3 cycles, no PSEL gap beyond one IDLE cycle, and a protocol checker (SETUP→ACCESS ordering, stable PADDR) passes.
- Reset in ACCESS: assert PRESET during ACCESS with a wait-stated slave → PSEL/PENABLE are 0 on the next edge, no rsp_valid, and a following read of 0x04 completes normally.
